piece_queue: RTL and testbench
==============================

PIECE_QUEUE -- requirements
Module: piece_queue

Interface
REQ-001 Parameter NUM_SHAPES, default 7: number of distinct shapes; legal range 2..16.
REQ-002 Parameter QUEUE_DEPTH, default 4: entries held (head plus previews); legal range 2..8.
REQ-003 Parameter POS_W, default 8: spawn position width.
REQ-004 Parameter SPAWN_POS, default 128: spawn position presented with every piece.
REQ-005 Parameter SEED, default 16'hACE1: LFSR value after reset and on a zero seed load; SHALL be nonzero.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 pop  in  1  consumer takes the head piece this cycle.
REQ-009 seed_load  in  1  reload the LFSR and flush the queue.
REQ-010 seed_val  in  16  new LFSR value.
REQ-011 piece_valid  out  1  head entry is valid.
REQ-012 piece_shape  out  4  head shape.
REQ-013 piece_rot  out  2  head rotation (0/90/180/270 degrees).
REQ-014 piece_pos  out  POS_W  constant SPAWN_POS.
REQ-015 preview_shapes  out  4*QUEUE_DEPTH  bits [4i+3:4i] = shape of entry i (entry 0 = head); 0 for invalid entries.
REQ-016 count  out  4  number of valid entries.

Function
REQ-017 LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1; advances every cycle except a seed_load cycle.
REQ-018 Candidate, taken from the current (pre-advance) LFSR value: shape = lfsr[3:0], rot = lfsr[5:4].
REQ-019 Candidate rejected when shape >= NUM_SHAPES; a rejected candidate causes no push that cycle.
REQ-020 Push: accepted candidate written to the tail when count < QUEUE_DEPTH, or when count == QUEUE_DEPTH and a pop occurs in the same cycle.
REQ-021 Pop: effective only when pop && piece_valid; entries shift toward the head by one.
REQ-022 pop while piece_valid == 0 is ignored: no underflow, count unchanged.
REQ-023 Simultaneous pop and push: count unchanged; new entry lands at the new tail.
REQ-024 Push latency: an accepted candidate is visible in the outputs after 1 clock edge.
REQ-025 piece_valid = (count != 0); head outputs are 0 when invalid.
REQ-026 seed_load: lfsr <= seed_val, or SEED if seed_val == 0; count <= 0; bag mask cleared; no push or pop that cycle.
REQ-027 seed_load has priority over pop.

Reset
REQ-028 Asynchronous assertion values: lfsr = SEED, count = 0, piece_valid = 0, piece_shape = 0, piece_rot = 0, piece_pos = SPAWN_POS, preview_shapes = 0, bag mask = 0.
REQ-029 Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock edge.

Configuration
REQ-030 Macro PIECE_BAG_RANDOMIZER_EN defined: maintain a NUM_SHAPES-bit used mask; a candidate whose shape is already used is rejected.
REQ-031 Bag mode, mask update: each push sets its shape's bit; a push that completes the mask clears the mask in that same cycle, so every aligned group of NUM_SHAPES pushes contains each shape exactly once.
REQ-032 Macro undefined: no mask logic; only the REQ-019 range rejection applies, and repeats are allowed.

Verification
REQ-033 Reset release, pop = 0 -> after the 1st edge: piece_valid = 1, piece_shape = 1, piece_rot = 2 (from 0xACE1); count never exceeds 4.
REQ-034 Bag enabled, pop = 1 for 700 cycles -> every aligned group of 7 popped shapes is a permutation of 0..6.
REQ-035 seed_load = 1, seed_val = 0 mid-run -> next cycle count = 0, piece_valid = 0; the following piece is shape 1, rot 2.
REQ-036 Drain with pop = 1 while count = 0 -> count stays 0, no X on outputs, no underflow.
REQ-037 count = 4, pop = 1 with an accepted candidate -> count stays 4; new piece_shape equals the prior preview_shapes[7:4].
REQ-038 Async reset pulsed between clock edges with count = 3 -> outputs take REQ-028 values immediately.

Source files
------------

// File: rtl/piece_queue_if.sv
// Handshake bundle between the piece generator and its consumer.
// The consumer drives pop and the seed controls. The generator drives the head piece, the previews and the count.
interface piece_queue_if #(
    parameter int QUEUE_DEPTH = 4,
    parameter int POS_W       = 8
);
    logic                     pop;
    logic                     seed_load;
    logic [15:0]              seed_val;
    logic                     piece_valid;
    logic [3:0]               piece_shape;
    logic [1:0]               piece_rot;
    logic [POS_W-1:0]         piece_pos;
    logic [4*QUEUE_DEPTH-1:0] preview_shapes;
    logic [3:0]               count;

    modport master (
        output pop, seed_load, seed_val,
        input  piece_valid, piece_shape, piece_rot, piece_pos, preview_shapes, count
    );

    modport slave (
        input  pop, seed_load, seed_val,
        output piece_valid, piece_shape, piece_rot, piece_pos, preview_shapes, count
    );
endinterface

// File: rtl/piece_queue.sv
// LFSR-fed piece queue: a head piece plus previews, filled with random shapes and rotations.
// Defining PIECE_BAG_RANDOMIZER_EN enables bag mode. In bag mode each aligned group of NUM_SHAPES pushes holds every shape once.
module piece_queue #(
    parameter int          NUM_SHAPES  = 7,
    parameter int          QUEUE_DEPTH = 4,
    parameter int          POS_W       = 8,
    parameter int          SPAWN_POS   = 128,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    piece_queue_if.slave bus
);
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] TAPS    = 16'hB400;
    localparam logic [3:0]  DEPTH_C = 4'(QUEUE_DEPTH);

    logic [15:0]                  lfsr_reg, lfsr_next;
    logic [3:0]                   count_reg, count_next;
    logic [QUEUE_DEPTH-1:0][3:0]  shape_reg, shape_next;
    logic [QUEUE_DEPTH-1:0][1:0]  rot_reg, rot_next;

    logic [3:0] cand_shape;
    logic [1:0] cand_rot;
    logic       cand_in_range;
    logic       shape_used;
    logic       pop_eff;
    logic       push_en;
    logic [3:0] base_count;

    assign cand_shape    = lfsr_reg[3:0];
    assign cand_rot      = lfsr_reg[5:4];
    assign cand_in_range = ({1'b0, cand_shape} < 5'(NUM_SHAPES));

    assign pop_eff    = bus.pop && (count_reg != 4'd0) && !bus.seed_load;
    assign base_count = count_reg - {3'b000, pop_eff};
    // A full queue still accepts a push when the head leaves in the same cycle
    assign push_en    = !bus.seed_load && cand_in_range && !shape_used && (base_count < DEPTH_C);
    assign count_next = bus.seed_load ? 4'd0 : base_count + {3'b000, push_en};

    assign lfsr_next = bus.seed_load ? ((bus.seed_val == 16'd0) ? SEED : bus.seed_val)
                                     : (lfsr_reg[0] ? ((lfsr_reg >> 1) ^ TAPS) : (lfsr_reg >> 1));

`ifdef PIECE_BAG_RANDOMIZER_EN
    logic [NUM_SHAPES-1:0] mask_reg, mask_next, mask_set;
    logic [15:0]           mask_wide;
    logic [15:0]           cand_onehot;

    assign mask_wide   = 16'(mask_reg);
    assign shape_used  = mask_wide[cand_shape];
    assign cand_onehot = 16'd1 << cand_shape;
    assign mask_set    = mask_reg | cand_onehot[NUM_SHAPES-1:0];
    // Completing the bag starts the next one in the same cycle
    assign mask_next   = bus.seed_load ? '0 :
                         push_en       ? ((&mask_set) ? '0 : mask_set) :
                                         mask_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_reg <= '0;
        end else begin
            mask_reg <= mask_next;
        end
    end
`else
    assign shape_used = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
            logic [3:0] up_shape;
            logic [1:0] up_rot;
            logic       push_here;

            if (gi == QUEUE_DEPTH - 1) begin : g_tail
                assign up_shape = 4'd0;
                assign up_rot   = 2'd0;
            end else begin : g_body
                assign up_shape = shape_reg[gi+1];
                assign up_rot   = rot_reg[gi+1];
            end

            // The tail slot is indexed by the count left after any pop
            assign push_here = push_en && (base_count == 4'(gi));

            assign shape_next[gi] = bus.seed_load ? 4'd0 :
                                    push_here     ? cand_shape :
                                    pop_eff       ? up_shape : shape_reg[gi];
            assign rot_next[gi]   = bus.seed_load ? 2'd0 :
                                    push_here     ? cand_rot :
                                    pop_eff       ? up_rot : rot_reg[gi];

            assign bus.preview_shapes[4*gi +: 4] = (4'(gi) < count_reg) ? shape_reg[gi] : 4'd0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg  <= SEED;
            count_reg <= 4'd0;
            shape_reg <= '0;
            rot_reg   <= '0;
        end else begin
            lfsr_reg  <= lfsr_next;
            count_reg <= count_next;
            shape_reg <= shape_next;
            rot_reg   <= rot_next;
        end
    end

    assign bus.piece_valid = (count_reg != 4'd0);
    assign bus.piece_shape = bus.piece_valid ? shape_reg[0] : 4'd0;
    assign bus.piece_rot   = bus.piece_valid ? rot_reg[0] : 2'd0;
    assign bus.piece_pos   = POS_W'(SPAWN_POS);
    assign bus.count       = count_reg;
endmodule

// File: tb/tb_piece_queue.sv
// Bench for piece_queue: a hand-derived vector table, corner sequences and a randomized run against a queue model.
// When PIECE_BAG_RANDOMIZER_EN is defined, the bench also checks that every aligned group of popped shapes is a full bag.
module tb_piece_queue;
    localparam int          NS   = 7;
    localparam int          D    = 4;
    localparam int          PW   = 8;
    localparam int          SPOS = 128;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk;
    logic reset;

    piece_queue_if #(.QUEUE_DEPTH(D), .POS_W(PW)) bus ();

    piece_queue #(
        .NUM_SHAPES (NS),
        .QUEUE_DEPTH(D),
        .POS_W      (PW),
        .SPAWN_POS  (SPOS),
        .SEED       (SEED)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] shape;
        logic [1:0] rot;
    } ent_t;

    typedef struct {
        logic [3:0]  count;
        logic        valid;
        logic [3:0]  shape;
        logic [1:0]  rot;
        logic [15:0] preview;
    } exp_t;

    typedef struct {
        logic        pop;
        logic        sl;
        logic [15:0] sv;
        logic [3:0]  count;
        logic [3:0]  shape;
        logic [1:0]  rot;
        logic [15:0] preview;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [15:0] m_lfsr;
    logic [15:0] m_mask;
    ent_t        m_q[$];
    exp_t        sb[$];
    vec_t        vecs[17];

`ifdef PIECE_BAG_RANDOMIZER_EN
    logic        bag_track = 1'b0;
    logic [15:0] grp_mask  = 16'd0;
    int          grp_n     = 0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got 0x%0h, required 0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic model_reset();
        m_lfsr = SEED;
        m_mask = 16'd0;
        m_q.delete();
    endtask

    task automatic model_step(input logic p, input logic sl, input logic [15:0] sv);
        exp_t       e;
        ent_t       tmp;
        logic [3:0] sh;
        logic [1:0] rt;
        logic       ok;
        if (sl) begin
            m_lfsr = (sv == 16'd0) ? SEED : sv;
            m_mask = 16'd0;
            m_q.delete();
        end else begin
            sh = m_lfsr[3:0];
            rt = m_lfsr[5:4];
            ok = (int'(sh) < NS);
`ifdef PIECE_BAG_RANDOMIZER_EN
            if (ok && m_mask[sh]) ok = 1'b0;
`endif
            if (p && m_q.size() > 0) void'(m_q.pop_front());
            if (ok && m_q.size() < D) begin
                tmp.shape = sh;
                tmp.rot   = rt;
                m_q.push_back(tmp);
`ifdef PIECE_BAG_RANDOMIZER_EN
                m_mask[sh] = 1'b1;
                if (m_mask == 16'((1 << NS) - 1)) m_mask = 16'd0;
`endif
            end
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
        e.count   = 4'(m_q.size());
        e.valid   = (m_q.size() != 0);
        e.shape   = e.valid ? m_q[0].shape : 4'd0;
        e.rot     = e.valid ? m_q[0].rot : 2'd0;
        e.preview = 16'd0;
        foreach (m_q[i]) e.preview[4*i +: 4] = m_q[i].shape;
        sb.push_back(e);
    endtask

    // Drive one cycle, predict it, then compare on the falling edge that follows
    task automatic drive_cycle(input logic p, input logic sl, input logic [15:0] sv);
        exp_t e;
        bus.pop       = p;
        bus.seed_load = sl;
        bus.seed_val  = sv;
        model_step(p, sl, sv);
`ifdef PIECE_BAG_RANDOMIZER_EN
        if (bag_track && p && !sl && bus.piece_valid) begin
            grp_mask = grp_mask | (16'd1 << bus.piece_shape);
            grp_n++;
            if (grp_n == NS) begin
                check("bag_perm", 32'(grp_mask), 32'((1 << NS) - 1));
                grp_mask = 16'd0;
                grp_n    = 0;
            end
        end
`endif
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("sb_count",   32'(bus.count),          32'(e.count));
            check("sb_valid",   32'(bus.piece_valid),    32'(e.valid));
            check("sb_shape",   32'(bus.piece_shape),    32'(e.shape));
            check("sb_rot",     32'(bus.piece_rot),      32'(e.rot));
            check("sb_preview", 32'(bus.preview_shapes), 32'(e.preview));
        end
        $display("cyc %0d pop=%0b seed_load=%0b count=%0d head=%0d rot=%0d preview=%04h",
                 cyc, p, sl, bus.count, bus.piece_shape, bus.piece_rot, bus.preview_shapes);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},   32'(bus.count),          32'd0);
        check({tag, "_valid"},   32'(bus.piece_valid),    32'd0);
        check({tag, "_shape"},   32'(bus.piece_shape),    32'd0);
        check({tag, "_rot"},     32'(bus.piece_rot),      32'd0);
        check({tag, "_pos"},     32'(bus.piece_pos),      32'(SPOS));
        check({tag, "_preview"}, 32'(bus.preview_shapes), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Head shape/rot follow the LFSR sequence ACE1, E270, 7138, 389C, 1C4E, 0E27, B313, ED89, C2C4, 6162.
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 4'd1, 4'd1, 2'd2, 16'h0001};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 4'd2, 4'd1, 2'd2, 16'h0001};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 4'd2, 4'd1, 2'd2, 16'h0001};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 4'd2, 4'd1, 2'd2, 16'h0001};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 4'd2, 4'd1, 2'd2, 16'h0001};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 4'd2, 4'd1, 2'd2, 16'h0001};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 4'd3, 4'd1, 2'd2, 16'h0301};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 4'd3, 4'd1, 2'd2, 16'h0301};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 4'd4, 4'd1, 2'd2, 16'h4301};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 4'd4, 4'd0, 2'd3, 16'h2430};
        vecs[10] = '{1'b1, 1'b1, 16'h0000, 4'd0, 4'd0, 2'd0, 16'h0000};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 4'd1, 4'd1, 2'd2, 16'h0001};
        vecs[12] = '{1'b1, 1'b1, 16'h000F, 4'd0, 4'd0, 2'd0, 16'h0000};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, 4'd0, 4'd0, 2'd0, 16'h0000};
        vecs[14] = '{1'b1, 1'b0, 16'h0000, 4'd0, 4'd0, 2'd0, 16'h0000};
        vecs[15] = '{1'b1, 1'b0, 16'h0000, 4'd1, 4'd3, 2'd0, 16'h0003};
        vecs[16] = '{1'b1, 1'b0, 16'h0000, 4'd1, 4'd1, 2'd0, 16'h0001};

        reset         = 1'b1;
        bus.pop       = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_val  = 16'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive_cycle(vecs[i].pop, vecs[i].sl, vecs[i].sv);
            check($sformatf("vec%0d_count", i), 32'(bus.count),          32'(vecs[i].count));
            check($sformatf("vec%0d_valid", i), 32'(bus.piece_valid),    32'(vecs[i].count != 4'd0));
            check($sformatf("vec%0d_shape", i), 32'(bus.piece_shape),    32'(vecs[i].shape));
            check($sformatf("vec%0d_rot", i),   32'(bus.piece_rot),      32'(vecs[i].rot));
            check($sformatf("vec%0d_prev", i),  32'(bus.preview_shapes), 32'(vecs[i].preview));
            check($sformatf("vec%0d_pos", i),   32'(bus.piece_pos),      32'(SPOS));
        end

        // Reset pulsed between edges while three entries are held
        drive_cycle(1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 7; i++) drive_cycle(1'b0, 1'b0, 16'h0000);
        check("pre_async_count", 32'(bus.count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        model_reset();
        #1;
        reset = 1'b0;
        drive_cycle(1'b0, 1'b0, 16'h0000);
        check("post_async_shape", 32'(bus.piece_shape), 32'd1);
        check("post_async_rot",   32'(bus.piece_rot),   32'd2);

        for (int i = 0; i < 300; i++) begin
            logic        p;
            logic        sl;
            logic [15:0] sv;
            p  = ($urandom_range(0, 99) < 70);
            sl = ($urandom_range(0, 49) == 0);
            sv = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            drive_cycle(p, sl, sv);
        end

        // Continuous drain after a flush so bag groups stay aligned
        drive_cycle(1'b1, 1'b1, 16'h1234);
`ifdef PIECE_BAG_RANDOMIZER_EN
        bag_track = 1'b1;
        grp_mask  = 16'd0;
        grp_n     = 0;
`endif
        for (int i = 0; i < 700; i++) drive_cycle(1'b1, 1'b0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
